// File: rtl/mem_bus_reader.sv
// mem_bus_reader
//   Read-side controller for the shared tri-state result bus in the MEM/WB
//   area. A request names one source. The controller first holds every
//   chip-select inactive for one turnaround edge, so that the old and new
//   drivers never overlap. It then enables the selected source, waits
//   SettleCycles advancing edges, captures the bus and presents the word
//   downstream with a valid/ready handshake. State only moves on edges where
//   ClockEnable & Tick is high, which is the same gating the bus drivers use.
//
// Ports
//   Clock, Reset      : posedge clock, asynchronous active-high reset
//   ClockEnable, Tick : an edge advances only when both are 1
//   ReqValid/ReqSel   : read request and source index
//   ReqReady          : high in IDLE only
//   Bus               : shared bus as seen at the reader
//   CsN               : per-source chip-select, 0 = source drives the bus
//   RdValid/RdData    : captured word and its valid flag
//   RdSel/RdErr       : source index of the word; RdErr flags an out-of-range
//                       index (RdData is then 0)
//   RdReady           : downstream accept
//   Busy              : state is not IDLE
module mem_bus_reader #(
    parameter int NrOfBits     = 32,
    parameter int NrOfSources  = 4,
    parameter int SelBits      = 2,
    parameter int SettleCycles = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   ClockEnable,
    input  logic                   Tick,
    input  logic                   ReqValid,
    input  logic [SelBits-1:0]     ReqSel,
    output logic                   ReqReady,
    input  logic [NrOfBits-1:0]    Bus,
    output logic [NrOfSources-1:0] CsN,
    output logic                   RdValid,
    output logic [NrOfBits-1:0]    RdData,
    output logic [SelBits-1:0]     RdSel,
    output logic                   RdErr,
    input  logic                   RdReady,
    output logic                   Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // The extra top bit lets the range check work even when NrOfSources
    // equals 2**SelBits.
    localparam logic [SelBits:0] NrSrc      = (SelBits + 1)'(NrOfSources);
    localparam logic [3:0]       SettleLast = 4'(SettleCycles - 1);

    state_t                   state_q, state_d;
    logic [NrOfSources-1:0]   cs_n_q, cs_n_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [NrOfBits-1:0]      rd_data_q, rd_data_d;
    logic [SelBits-1:0]       rd_sel_q, rd_sel_d;
    logic                     rd_err_q, rd_err_d;
    logic [3:0]               cnt_q, cnt_d;

    logic advance;
    logic sel_ok;

    assign advance = ClockEnable & Tick;
    assign sel_ok  = ({1'b0, ReqSel} < NrSrc);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cs_n_q     <= '1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_sel_q   <= '0;
            rd_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_sel_q   <= rd_sel_d;
            rd_err_q   <= rd_err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_sel_d   = rd_sel_q;
        rd_err_d   = rd_err_q;
        cnt_d      = cnt_q;

        if (advance) begin
            unique case (state_q)
                IDLE: begin
                    cs_n_d = '1;
                    if (ReqValid) begin
                        rd_sel_d = ReqSel;
                        if (sel_ok) begin
                            state_d = TURN;
                        end else begin
                            // No source to enable: answer with an error word
                            // straight away, the bus is never touched.
                            state_d    = HOLD;
                            rd_data_d  = '0;
                            rd_err_d   = 1'b1;
                            rd_valid_d = 1'b1;
                        end
                    end
                end
                TURN: begin
                    // One edge with every source released has passed; now
                    // enable only the requested source.
                    state_d = SETTLE;
                    cnt_d   = '0;
                    cs_n_d  = '1;
                    for (int i = 0; i < NrOfSources; i++) begin
                        if (SelBits'(i) == rd_sel_q) begin
                            cs_n_d[i] = 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == SettleLast) begin
                        rd_data_d  = Bus;
                        rd_err_d   = 1'b0;
                        rd_valid_d = 1'b1;
                        cs_n_d     = '1;
                        state_d    = HOLD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (RdReady) begin
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                end
            endcase
        end
    end

    assign ReqReady = (state_q == IDLE);
    assign Busy     = (state_q != IDLE);
    assign CsN      = cs_n_q;
    assign RdValid  = rd_valid_q;
    assign RdData   = rd_data_q;
    assign RdSel    = rd_sel_q;
    assign RdErr    = rd_err_q;

endmodule

// File: tb/tb_mem_bus_reader.sv
// tb_mem_bus_reader
//   Two readers share one clock: u0 uses the default parameters (4 sources,
//   settle 1) and u1 uses 3 sources with settle 3. Each reader sees a bus
//   model that drives a fixed word per source while that source's CsN is 0.
//   Expected read results are queued when a request is driven and compared
//   when the reader presents its word.
module tb_mem_bus_reader;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        tick;
    logic        rv [2];
    logic [1:0]  rs [2];
    logic        rr [2];

    logic        req_ready0, req_ready1;
    logic [31:0] bus0, bus1;
    logic [3:0]  cs_n0;
    logic [2:0]  cs_n1;
    logic        rd_valid0, rd_valid1;
    logic [31:0] rd_data0, rd_data1;
    logic [1:0]  rd_sel0, rd_sel1;
    logic        rd_err0, rd_err1;
    logic        busy0, busy1;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic gate_ce = 1'b0;

    mem_bus_reader u0 (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick),
        .ReqValid(rv[0]), .ReqSel(rs[0]), .ReqReady(req_ready0),
        .Bus(bus0), .CsN(cs_n0), .RdValid(rd_valid0), .RdData(rd_data0),
        .RdSel(rd_sel0), .RdErr(rd_err0), .RdReady(rr[0]), .Busy(busy0)
    );

    mem_bus_reader #(.NrOfSources(3), .SettleCycles(3)) u1 (
        .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick),
        .ReqValid(rv[1]), .ReqSel(rs[1]), .ReqReady(req_ready1),
        .Bus(bus1), .CsN(cs_n1), .RdValid(rd_valid1), .RdData(rd_data1),
        .RdSel(rd_sel1), .RdErr(rd_err1), .RdReady(rr[1]), .Busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] src(int i);
        case (i)
            0:       return 32'h1234_5678;
            1:       return 32'hCAFE_0001;
            2:       return 32'hDEAD_BEEF;
            default: return 32'h0F0F_F0F0;
        endcase
    endfunction

    // Source registers drive the bus while their chip-select is low.
    always_comb begin
        bus0 = '0;
        for (int i = 0; i < 4; i++) if (!cs_n0[i]) bus0 = src(i);
    end
    always_comb begin
        bus1 = '0;
        for (int i = 0; i < 3; i++) if (!cs_n1[i]) bus1 = src(i);
    end

    function automatic logic [3:0] csn(int u);
        return (u == 0) ? cs_n0 : {1'b1, cs_n1};
    endfunction
    function automatic logic vld(int u);
        return (u == 0) ? rd_valid0 : rd_valid1;
    endfunction
    function automatic logic [31:0] dat(int u);
        return (u == 0) ? rd_data0 : rd_data1;
    endfunction
    function automatic logic [1:0] rsel(int u);
        return (u == 0) ? rd_sel0 : rd_sel1;
    endfunction
    function automatic logic rerr(int u);
        return (u == 0) ? rd_err0 : rd_err1;
    endfunction
    function automatic logic qrdy(int u);
        return (u == 0) ? req_ready0 : req_ready1;
    endfunction
    function automatic logic bsy(int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // per-1 non-advancing edges (Tick low, or ClockEnable low when gate_ce
    // is set) followed by one advancing edge. Nothing may move on the
    // non-advancing edges.
    task automatic tick_edge(input int u, input int per);
        logic [3:0]  c;
        logic        v, b;
        logic [31:0] d;
        for (int k = 0; k < per - 1; k++) begin
            c = csn(u); v = vld(u); d = dat(u); b = bsy(u);
            if (gate_ce) begin ce = 1'b0; tick = 1'b1; end
            else         begin ce = 1'b1; tick = 1'b0; end
            cyc();
            check("hold_csn",  csn(u), c);
            check("hold_vld",  vld(u), v);
            check("hold_data", dat(u), d);
            check("hold_busy", bsy(u), b);
        end
        ce = 1'b1; tick = 1'b1;
        cyc();
    endtask

    task automatic issue(input int u, input int sel);
        exp_t e;
        int   ns;
        ns    = (u == 0) ? 4 : 3;
        e.sel = 2'(sel);
        e.err = (sel >= ns);
        e.data = e.err ? 32'h0 : src(sel);
        sbq.push_back(e);
        rv[u] = 1'b1;
        rs[u] = 2'(sel);
    endtask

    task automatic accept(input int u, input int per);
        check("acc_rdy", qrdy(u), 1'b1);
        tick_edge(u, per);
        rv[u] = 1'b0;
    endtask

    task automatic to_hold(input int u, input int sel, input int per);
        int         ns, st;
        logic [3:0] low;
        exp_t       e;
        ns = (u == 0) ? 4 : 3;
        st = (u == 0) ? 1 : 3;
        if (sel < ns) begin
            check("turn_csn",  csn(u), 4'hF);
            check("turn_busy", bsy(u), 1'b1);
            check("turn_rdy",  qrdy(u), 1'b0);
            check("turn_vld",  vld(u), 1'b0);
            low = 4'hF;
            low[sel] = 1'b0;
            tick_edge(u, per);
            for (int k = 0; k < st; k++) begin
                check("settle_csn", csn(u), low);
                check("settle_vld", vld(u), 1'b0);
                tick_edge(u, per);
            end
        end
        check("hold_valid", vld(u), 1'b1);
        check("hold_csn_off", csn(u), 4'hF);
        check("hold_rdy", qrdy(u), 1'b0);
        check("hold_busy1", bsy(u), 1'b1);
        if (sbq.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
        end else begin
            e = sbq.pop_front();
            check("rd_data", dat(u), e.data);
            check("rd_sel", rsel(u), e.sel);
            check("rd_err", rerr(u), e.err);
        end
    endtask

    task automatic release_rd(input int u, input int per);
        rr[u] = 1'b1;
        tick_edge(u, per);
        check("rel_vld", vld(u), 1'b0);
        check("rel_busy", bsy(u), 1'b0);
        check("rel_rdy", qrdy(u), 1'b1);
        check("rel_csn", csn(u), 4'hF);
        rr[u] = 1'b0;
    endtask

    task automatic read(input int u, input int sel, input int per);
        issue(u, sel);
        accept(u, per);
        to_hold(u, sel, per);
        release_rd(u, per);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; tick = 1'b0;
        for (int u = 0; u < 2; u++) begin rv[u] = 1'b0; rs[u] = '0; rr[u] = 1'b0; end
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_csn", csn(u), 4'hF);
            check("rst_vld", vld(u), 1'b0);
            check("rst_data", dat(u), 32'h0);
            check("rst_sel", rsel(u), 2'd0);
            check("rst_err", rerr(u), 1'b0);
            check("rst_rdy", qrdy(u), 1'b1);
            check("rst_busy", bsy(u), 1'b0);
        end
        @(negedge clk);
        rst = 1'b0; ce = 1'b1; tick = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("idle_csn0", csn(0), 4'hF);
            check("idle_csn1", csn(1), 4'hF);
        end

        // Basic read of source 2, default settle.
        read(0, 2, 1);

        // Reset while source 2 is enabled.
        issue(0, 2);
        accept(0, 1);
        tick_edge(0, 1);
        check("pre_rst_csn", csn(0), 4'b1011);
        rst = 1'b1;
        #1;
        check("mid_rst_csn", csn(0), 4'hF);
        check("mid_rst_vld", vld(0), 1'b0);
        check("mid_rst_busy", bsy(0), 1'b0);
        check("mid_rst_rdy", qrdy(0), 1'b1);
        check("mid_rst_data", dat(0), 32'h0);
        void'(sbq.pop_front());
        #1;
        rst = 1'b0;
        tick_edge(0, 1);
        check("post_rst_csn", csn(0), 4'hF);

        // Tick gating, then ClockEnable gating.
        read(0, 2, 3);
        gate_ce = 1'b1;
        read(0, 1, 2);
        gate_ce = 1'b0;

        // Backpressure with a second request waiting.
        issue(0, 1);
        accept(0, 1);
        to_hold(0, 1, 1);
        issue(0, 3);
        for (int k = 0; k < 5; k++) begin
            tick_edge(0, 1);
            check("bp_data", dat(0), src(1));
            check("bp_vld", vld(0), 1'b1);
            check("bp_rdy", qrdy(0), 1'b0);
        end
        release_rd(0, 1);
        accept(0, 1);
        to_hold(0, 3, 1);
        release_rd(0, 1);

        // Out-of-range index and the longer settle on the 3-source reader.
        read(1, 3, 1);
        read(1, 0, 1);
        read(1, 2, 2);
        for (int s = 0; s < 4; s++) read(0, s, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
